// File: rtl/mdu_pkg.sv
// Shared types and latency helpers for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        READ_HI  = 4'd0,
        READ_LO  = 4'd1,
        WRITE_HI = 4'd2,
        WRITE_LO = 4'd3,
        MUL      = 4'd4,
        MULU     = 4'd5,
        DIV      = 4'd6,
        DIVU     = 4'd7,
        MADD     = 4'd8,
        MADDU    = 4'd9,
        MSUB     = 4'd10,
        MSUBU    = 4'd11
    } mdu_operation_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_ITER = 2'd1,
        DIV_ITER = 2'd2,
        FIXUP    = 2'd3
    } mdu_state_t;

    // Busy cycles from the accept edge: iterations plus the FIXUP cycle.
    function automatic int mul_latency(input int width, input int step);
        return width / step + 1;
    endfunction

    function automatic int div_latency(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/iterative_mul_div_unit_if.sv
// Command/result bus of the multiply/divide unit; master issues, slave executes.
interface iterative_mul_div_unit_if #(parameter int WIDTH = 32);
    import mdu_pkg::*;

    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    mdu_operation_t   operation;
    logic             start;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_read;

    modport master (
        output operand1, operand2, operation, start, flush,
        input  busy, done, data_read
    );

    modport slave (
        input  operand1, operand2, operation, start, flush,
        output busy, done, data_read
    );

endinterface

// File: rtl/mdu_divider_step.sv
// One restoring-division iteration: trial subtract of the divisor from the shifted remainder.
module mdu_divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   partial_rem,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] diff;

    always_comb begin
        diff     = partial_rem - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        next_rem = q_bit ? diff[WIDTH-1:0] : partial_rem[WIDTH-1:0];
    end

endmodule

// File: rtl/iterative_mul_div_unit.sv
// Iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// Define MDU_ACCUMULATE_EN to enable MADD/MADDU/MSUB/MSUBU.
module iterative_mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    iterative_mul_div_unit_if.slave bus
);

    localparam int CNT_W      = $clog2(WIDTH + 1);
    localparam int MUL_CYCLES = mul_latency(WIDTH, MUL_STEP) - 1;
    localparam int DIV_CYCLES = div_latency(WIDTH) - 1;

    mdu_state_t       state;
    mdu_operation_t   op_q;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] hi, lo;
    logic [2*WIDTH-1:0] prod, mcand;
    logic [WIDTH-1:0] shreg, rem, divisor;
    logic             res_neg, rem_neg, div_zero;
    logic             busy_q, done_q;

    logic             is_signed, is_mul, is_div, can_accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] mul_sum, mul_res, fix_mul;
    logic [WIDTH-1:0] quot, rmd, div_rem_next;
    logic             div_q_bit;

    always_comb begin
        is_signed  = bus.operation inside {MUL, DIV, MADD, MSUB};
`ifdef MDU_ACCUMULATE_EN
        is_mul     = bus.operation inside {MUL, MULU, MADD, MADDU, MSUB, MSUBU};
`else
        is_mul     = bus.operation inside {MUL, MULU};
`endif
        is_div     = bus.operation inside {DIV, DIVU};
        can_accept = (state == IDLE) && bus.start && !bus.flush;
        a_neg      = is_signed & bus.operand1[WIDTH-1];
        b_neg      = is_signed & bus.operand2[WIDTH-1];
        a_mag      = a_neg ? -bus.operand1 : bus.operand1;
        b_mag      = b_neg ? -bus.operand2 : bus.operand2;
    end

    always_comb begin
        mul_sum = prod;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (shreg[i]) mul_sum = mul_sum + (mcand << i);
        end
    end

    mdu_divider_step #(.WIDTH(WIDTH)) u_div_step (
        .partial_rem ({rem, shreg[WIDTH-1]}),
        .divisor     (divisor),
        .next_rem    (div_rem_next),
        .q_bit       (div_q_bit)
    );

    // Magnitude results are re-signed here; accumulate uses HI/LO as of FIXUP.
    always_comb begin
        mul_res = res_neg ? -prod : prod;
        quot    = res_neg ? -shreg : shreg;
        rmd     = rem_neg ? -rem : rem;
`ifdef MDU_ACCUMULATE_EN
        if (op_q inside {MADD, MADDU})      fix_mul = {hi, lo} + mul_res;
        else if (op_q inside {MSUB, MSUBU}) fix_mul = {hi, lo} - mul_res;
        else                                fix_mul = mul_res;
`else
        fix_mul = mul_res;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= READ_HI;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            prod     <= '0;
            mcand    <= '0;
            shreg    <= '0;
            rem      <= '0;
            divisor  <= '0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_accept) begin
                        op_q <= bus.operation;
                        if (bus.operation == WRITE_HI) begin
                            hi <= bus.operand1;
                        end else if (bus.operation == WRITE_LO) begin
                            lo <= bus.operand1;
                        end else if (is_mul) begin
                            prod    <= '0;
                            mcand   <= {{WIDTH{1'b0}}, a_mag};
                            shreg   <= b_mag;
                            res_neg <= a_neg ^ b_neg;
                            count   <= CNT_W'(MUL_CYCLES);
                            busy_q  <= 1'b1;
                            state   <= MUL_ITER;
                        end else if (is_div) begin
                            rem      <= '0;
                            shreg    <= a_mag;
                            divisor  <= b_mag;
                            res_neg  <= a_neg ^ b_neg;
                            rem_neg  <= a_neg;
                            div_zero <= (bus.operand2 == '0);
                            busy_q   <= 1'b1;
                            if (bus.operand2 == '0) begin
                                count <= '0;
                                state <= FIXUP;
                            end else begin
                                count <= CNT_W'(DIV_CYCLES);
                                state <= DIV_ITER;
                            end
                        end
                    end
                end
                MUL_ITER: begin
                    if (bus.flush) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        count  <= '0;
                    end else begin
                        prod  <= mul_sum;
                        mcand <= mcand << MUL_STEP;
                        shreg <= shreg >> MUL_STEP;
                        count <= count - CNT_W'(1);
                        if (count == CNT_W'(1)) state <= FIXUP;
                    end
                end
                DIV_ITER: begin
                    if (bus.flush) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        count  <= '0;
                    end else begin
                        rem   <= div_rem_next;
                        shreg <= {shreg[WIDTH-2:0], div_q_bit};
                        count <= count - CNT_W'(1);
                        if (count == CNT_W'(1)) state <= FIXUP;
                    end
                end
                FIXUP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        if (op_q inside {DIV, DIVU}) begin
                            if (!div_zero) begin
                                hi <= rmd;
                                lo <= quot;
                            end
                        end else begin
                            {hi, lo} <= fix_mul;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    always_comb begin
        case (bus.operation)
            READ_HI: bus.data_read = hi;
            READ_LO: bus.data_read = lo;
            default: bus.data_read = '0;
        endcase
    end

endmodule
